l2_req_arb: RTL and testbench

L2_REQ_ARB -- requirements
Module: l2_req_arb

---
 rtl/l2_req_arb_if.sv | 48 ++++
 rtl/l2_req_arb.sv | 93 +++++++++
 tb/tb_l2_req_arb.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_req_arb_if.sv
// Bundle of the I-side, D-side and L2 handshake buses seen by the L2 request arbiter.
// master is the arbiter's view; slave is the view of the clients and the L2 together.
interface l2_req_arb_if;
  logic         l1i_req_valid;
  logic         l1i_req_ack;
  logic [31:0]  l1i_req_addr;
  logic         l1i_rsp_valid;
  logic [127:0] l1i_rsp_load_data;

  logic         l1d_req_valid;
  logic         l1d_req_ack;
  logic [31:0]  l1d_req_addr;
  logic [127:0] l1d_req_store_data;
  logic [3:0]   l1d_req_opcode;
  logic         l1d_rsp_valid;
  logic [127:0] l1d_rsp_load_data;

  logic         l2_req_valid;
  logic         l2_req_ack;
  logic [31:0]  l2_req_addr;
  logic [127:0] l2_req_store_data;
  logic [3:0]   l2_req_opcode;
  logic         l2_rsp_valid;
  logic [127:0] l2_rsp_load_data;

  logic [63:0]  i_grants;
  logic [63:0]  d_grants;

  modport master (
    input  l1i_req_valid, l1i_req_addr,
    output l1i_req_ack, l1i_rsp_valid, l1i_rsp_load_data,
    input  l1d_req_valid, l1d_req_addr, l1d_req_store_data, l1d_req_opcode,
    output l1d_req_ack, l1d_rsp_valid, l1d_rsp_load_data,
    output l2_req_valid, l2_req_addr, l2_req_store_data, l2_req_opcode,
    input  l2_req_ack, l2_rsp_valid, l2_rsp_load_data,
    output i_grants, d_grants
  );

  modport slave (
    output l1i_req_valid, l1i_req_addr,
    input  l1i_req_ack, l1i_rsp_valid, l1i_rsp_load_data,
    output l1d_req_valid, l1d_req_addr, l1d_req_store_data, l1d_req_opcode,
    input  l1d_req_ack, l1d_rsp_valid, l1d_rsp_load_data,
    input  l2_req_valid, l2_req_addr, l2_req_store_data, l2_req_opcode,
    output l2_req_ack, l2_rsp_valid, l2_rsp_load_data,
    input  i_grants, d_grants
  );
endinterface

// File: rtl/l2_req_arb.sv
// Round-robin arbiter merging L1I and L1D requests onto a single L2 port,
// one request outstanding at a time; every output is a register.
module l2_req_arb (
  input logic          clk,
  input logic          reset,
  l2_req_arb_if.master bus
);
  localparam logic [3:0] OP_LOAD = 4'd4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t state;
  logic   owner_d;   // current owner: 1 = D-side
  logic   last_d;    // most recent grant went to D-side
  logic   grant_d;
  logic   fwd;

  // On a tie the side not granted last wins.
  always_comb begin
    grant_d = bus.l1d_req_valid && (!bus.l1i_req_valid || !last_d);
    fwd     = bus.l2_rsp_valid &&
              ((state == WAIT_RSP) || ((state == ISSUE) && bus.l2_req_ack));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      owner_d               <= 1'b0;
      last_d                <= 1'b0;
      bus.l1i_req_ack       <= 1'b0;
      bus.l1d_req_ack       <= 1'b0;
      bus.l1i_rsp_valid     <= 1'b0;
      bus.l1d_rsp_valid     <= 1'b0;
      bus.l1i_rsp_load_data <= '0;
      bus.l1d_rsp_load_data <= '0;
      bus.l2_req_valid      <= 1'b0;
      bus.l2_req_addr       <= '0;
      bus.l2_req_store_data <= '0;
      bus.l2_req_opcode     <= '0;
      bus.i_grants          <= '0;
      bus.d_grants          <= '0;
    end else begin
      bus.l1i_req_ack   <= 1'b0;
      bus.l1d_req_ack   <= 1'b0;
      bus.l1i_rsp_valid <= 1'b0;
      bus.l1d_rsp_valid <= 1'b0;

      if (fwd) begin
        if (owner_d) begin
          bus.l1d_rsp_valid     <= 1'b1;
          bus.l1d_rsp_load_data <= bus.l2_rsp_load_data;
        end else begin
          bus.l1i_rsp_valid     <= 1'b1;
          bus.l1i_rsp_load_data <= bus.l2_rsp_load_data;
        end
      end

      case (state)
        IDLE: begin
          if (bus.l1i_req_valid || bus.l1d_req_valid) begin
            state            <= ISSUE;
            bus.l2_req_valid <= 1'b1;
            owner_d          <= grant_d;
            last_d           <= grant_d;
            if (grant_d) begin
              bus.l2_req_addr       <= bus.l1d_req_addr;
              bus.l2_req_opcode     <= bus.l1d_req_opcode;
              bus.l2_req_store_data <= bus.l1d_req_store_data;
              bus.l1d_req_ack       <= 1'b1;
              bus.d_grants          <= bus.d_grants + 64'd1;
            end else begin
              bus.l2_req_addr       <= bus.l1i_req_addr;
              bus.l2_req_opcode     <= OP_LOAD;
              bus.l2_req_store_data <= '0;
              bus.l1i_req_ack       <= 1'b1;
              bus.i_grants          <= bus.i_grants + 64'd1;
            end
          end
        end
        ISSUE: begin
          if (bus.l2_req_ack) begin
            bus.l2_req_valid <= 1'b0;
            state            <= fwd ? IDLE : WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (bus.l2_rsp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_req_arb.sv
// Directed and randomized bench for l2_req_arb against a transaction-level model.
module tb_l2_req_arb;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l2_req_arb_if bus ();
  l2_req_arb dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic         v;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [3:0]   op;
  } creq_t;

  int checks = 0;
  int failures = 0;

  creq_t        pi, pd;
  int           last_win, win, n, k;
  logic [63:0]  exp_ig, exp_dg;
  logic [127:0] exp_idata, exp_ddata, rdata;
  logic         same;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_clients();
    bus.l1i_req_valid      = pi.v;
    bus.l1i_req_addr       = pi.addr;
    bus.l1d_req_valid      = pd.v;
    bus.l1d_req_addr       = pd.addr;
    bus.l1d_req_store_data = pd.data;
    bus.l1d_req_opcode     = pd.op;
  endtask

  task automatic finish_same(input logic [127:0] d);
    bus.l2_req_ack = 1'b1; bus.l2_rsp_valid = 1'b1; bus.l2_rsp_load_data = d;
    tick();
    bus.l2_req_ack = 1'b0; bus.l2_rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pi = '{1'b0, 32'h0, 128'h0, 4'h0};
    pd = '{1'b0, 32'h0, 128'h0, 4'h0};
    drive_clients();
    bus.l2_req_ack = 1'b0; bus.l2_rsp_valid = 1'b0; bus.l2_rsp_load_data = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic chk_no_rsp(input string tag);
    chk({tag, "_irsp"}, bus.l1i_rsp_valid, 1'b0);
    chk({tag, "_drsp"}, bus.l1d_rsp_valid, 1'b0);
  endtask

  initial begin
    // ---------------- reset state
    do_reset();
    chk("rst_l2v", bus.l2_req_valid, 1'b0);
    chk("rst_iack", bus.l1i_req_ack, 1'b0);
    chk("rst_dack", bus.l1d_req_ack, 1'b0);
    chk_no_rsp("rst");
    chk("rst_addr", bus.l2_req_addr, 32'h0);
    chk("rst_sdata", bus.l2_req_store_data, 128'h0);
    chk("rst_op", bus.l2_req_opcode, 4'h0);
    chk("rst_idata", bus.l1i_rsp_load_data, 128'h0);
    chk("rst_ddata", bus.l1d_rsp_load_data, 128'h0);
    chk("rst_ig", bus.i_grants, 64'd0);
    chk("rst_dg", bus.d_grants, 64'd0);

    // ---------------- I-only load
    pi = '{1'b1, 32'h1000, 128'h0, 4'h0}; drive_clients();
    tick();
    chk("iload_ack", bus.l1i_req_ack, 1'b1);
    chk("iload_l2v", bus.l2_req_valid, 1'b1);
    chk("iload_op", bus.l2_req_opcode, 4'd4);
    chk("iload_addr", bus.l2_req_addr, 32'h1000);
    chk("iload_sdata", bus.l2_req_store_data, 128'h0);
    chk("iload_ig", bus.i_grants, 64'd1);
    pi.v = 1'b0; drive_clients();
    tick();
    chk("iload_ack_pulse", bus.l1i_req_ack, 1'b0);
    chk("iload_l2v_hold", bus.l2_req_valid, 1'b1);
    bus.l2_req_ack = 1'b1;
    tick();
    bus.l2_req_ack = 1'b0;
    chk("iload_l2v_drop", bus.l2_req_valid, 1'b0);
    chk_no_rsp("iload_wait");
    bus.l2_rsp_valid = 1'b1; bus.l2_rsp_load_data = {16{8'hAB}};
    tick();
    bus.l2_rsp_valid = 1'b0;
    chk("iload_rsp", bus.l1i_rsp_valid, 1'b1);
    chk("iload_rdata", bus.l1i_rsp_load_data, {16{8'hAB}});
    chk("iload_drsp", bus.l1d_rsp_valid, 1'b0);
    tick();
    chk("iload_rsp_pulse", bus.l1i_rsp_valid, 1'b0);
    chk("iload_rdata_hold", bus.l1i_rsp_load_data, {16{8'hAB}});

    // ---------------- D store, ack and rsp in one cycle
    pd = '{1'b1, 32'h2000, {16{8'h5A}}, 4'd7}; drive_clients();
    tick();
    chk("dst_ack", bus.l1d_req_ack, 1'b1);
    chk("dst_op", bus.l2_req_opcode, 4'd7);
    chk("dst_sdata", bus.l2_req_store_data, {16{8'h5A}});
    chk("dst_addr", bus.l2_req_addr, 32'h2000);
    pd.v = 1'b0; drive_clients();
    finish_same(128'h1234);
    chk("dst_rsp", bus.l1d_rsp_valid, 1'b1);
    chk("dst_irsp", bus.l1i_rsp_valid, 1'b0);
    chk("dst_l2v", bus.l2_req_valid, 1'b0);
    tick();
    chk("dst_rsp_pulse", bus.l1d_rsp_valid, 1'b0);
    chk("dst_dg", bus.d_grants, 64'd1);

    // ---------------- spurious responses/acks
    bus.l2_rsp_valid = 1'b1;
    tick();
    bus.l2_rsp_valid = 1'b0;
    chk_no_rsp("idle_rsp");
    chk("idle_l2v", bus.l2_req_valid, 1'b0);
    pi = '{1'b1, 32'h3000, 128'h0, 4'h0}; drive_clients();
    tick();
    chk("sp_iack", bus.l1i_req_ack, 1'b1);
    pi.v = 1'b0; drive_clients();
    bus.l2_rsp_valid = 1'b1;                // response without ack in ISSUE
    tick();
    bus.l2_rsp_valid = 1'b0;
    chk_no_rsp("issue_rsp");
    chk("issue_l2v", bus.l2_req_valid, 1'b1);
    bus.l2_req_ack = 1'b1;
    tick();                                  // -> WAIT_RSP
    tick();                                  // ack still high in WAIT_RSP
    bus.l2_req_ack = 1'b0;
    chk_no_rsp("wait_ack");
    chk("wait_l2v", bus.l2_req_valid, 1'b0);
    bus.l2_rsp_valid = 1'b1; bus.l2_rsp_load_data = 128'h77;
    tick();
    bus.l2_rsp_valid = 1'b0;
    chk("wait_rsp", bus.l1i_rsp_valid, 1'b1);
    chk("wait_rdata", bus.l1i_rsp_load_data, 128'h77);

    // ---------------- round-robin ties from reset
    do_reset();
    pi = '{1'b1, 32'h10, 128'h0, 4'h0};
    pd = '{1'b1, 32'h20, 128'h99, 4'd4};
    drive_clients();
    tick();
    chk("rr1_dack", bus.l1d_req_ack, 1'b1);
    chk("rr1_iack", bus.l1i_req_ack, 1'b0);
    chk("rr1_dg", bus.d_grants, 64'd1);
    chk("rr1_ig", bus.i_grants, 64'd0);
    finish_same(128'h1);
    tick();
    chk("rr2_iack", bus.l1i_req_ack, 1'b1);
    chk("rr2_ig", bus.i_grants, 64'd1);
    chk("rr2_dg", bus.d_grants, 64'd1);
    finish_same(128'h2);
    tick();
    chk("rr3_dack", bus.l1d_req_ack, 1'b1);
    chk("rr3_dg", bus.d_grants, 64'd2);
    pi.v = 1'b0; pd.v = 1'b0; drive_clients();
    finish_same(128'h3);

    // ---------------- reset while waiting for the response
    do_reset();
    pi = '{1'b1, 32'h40, 128'h0, 4'h0}; drive_clients();
    tick();
    pi.v = 1'b0; drive_clients();
    bus.l2_req_ack = 1'b1;
    tick();
    bus.l2_req_ack = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.l2_rsp_valid = 1'b1; bus.l2_rsp_load_data = 128'hDEAD;
    tick();
    bus.l2_rsp_valid = 1'b0;
    chk_no_rsp("rstmid");
    chk("rstmid_ig", bus.i_grants, 64'd0);
    chk("rstmid_dg", bus.d_grants, 64'd0);
    chk("rstmid_l2v", bus.l2_req_valid, 1'b0);
    tick();
    chk_no_rsp("rstmid2");

    // ---------------- randomized traffic vs transaction model
    do_reset();
    last_win = 0; exp_ig = '0; exp_dg = '0; exp_idata = '0; exp_ddata = '0;
    for (int it = 0; it < 60; it++) begin
      if (!pi.v && $urandom_range(0, 2) != 0)
        pi = '{1'b1, $urandom, 128'h0, 4'h0};
      if (!pd.v && $urandom_range(0, 2) != 0)
        pd = '{1'b1, $urandom, {$urandom, $urandom, $urandom, $urandom},
               ($urandom_range(0, 1) != 0) ? 4'd7 : 4'd4};
      if (!pi.v && !pd.v) pi = '{1'b1, $urandom, 128'h0, 4'h0};
      drive_clients();

      // Tie: the side not served last; otherwise whoever asks.
      if (pi.v && pd.v) win = 1 - last_win;
      else              win = pd.v ? 1 : 0;

      n = 0;
      do begin tick(); n++; end
      while (!(bus.l1i_req_ack || bus.l1d_req_ack) && n < 4);
      chk("rnd_grant_seen", bus.l1i_req_ack | bus.l1d_req_ack, 1'b1);
      chk("rnd_iack", bus.l1i_req_ack, win == 0);
      chk("rnd_dack", bus.l1d_req_ack, win == 1);
      chk("rnd_l2v", bus.l2_req_valid, 1'b1);
      if (win == 1) begin
        exp_dg++;
        chk("rnd_addr", bus.l2_req_addr, pd.addr);
        chk("rnd_op", bus.l2_req_opcode, pd.op);
        chk("rnd_sdata", bus.l2_req_store_data, pd.data);
      end else begin
        exp_ig++;
        chk("rnd_addr", bus.l2_req_addr, pi.addr);
        chk("rnd_op", bus.l2_req_opcode, 4'd4);
        chk("rnd_sdata", bus.l2_req_store_data, 128'h0);
      end
      chk("rnd_ig", bus.i_grants, exp_ig);
      chk("rnd_dg", bus.d_grants, exp_dg);
      last_win = win;
      same = (win == 1) && (pd.op == 4'd7) && ($urandom_range(0, 1) != 0);
      if (win == 1) pd.v = 1'b0; else pi.v = 1'b0;
      drive_clients();

      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        bus.l2_rsp_valid = ($urandom_range(0, 3) == 0);
        tick();
        bus.l2_rsp_valid = 1'b0;
        chk("rnd_issue_hold", bus.l2_req_valid, 1'b1);
        chk("rnd_ack_pulse", bus.l1i_req_ack | bus.l1d_req_ack, 1'b0);
        chk_no_rsp("rnd_issue");
      end

      rdata = {$urandom, $urandom, $urandom, $urandom};
      bus.l2_req_ack = 1'b1;
      bus.l2_rsp_valid = same; bus.l2_rsp_load_data = rdata;
      tick();
      bus.l2_req_ack = 1'b0; bus.l2_rsp_valid = 1'b0;
      chk("rnd_l2v_drop", bus.l2_req_valid, 1'b0);
      if (!same) begin
        chk_no_rsp("rnd_wait0");
        k = $urandom_range(0, 3);
        for (int j = 0; j < k; j++) begin
          bus.l2_req_ack = ($urandom_range(0, 3) == 0);
          tick();
          bus.l2_req_ack = 1'b0;
          chk_no_rsp("rnd_wait");
        end
        bus.l2_rsp_valid = 1'b1; bus.l2_rsp_load_data = rdata;
        tick();
        bus.l2_rsp_valid = 1'b0;
      end
      if (win == 1) exp_ddata = rdata; else exp_idata = rdata;
      chk("rnd_irsp", bus.l1i_rsp_valid, win == 0);
      chk("rnd_drsp", bus.l1d_rsp_valid, win == 1);
      chk("rnd_idata", bus.l1i_rsp_load_data, exp_idata);
      chk("rnd_ddata", bus.l1d_rsp_load_data, exp_ddata);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
